uncache_mem_arbiter: RTL

//   Shares the single uncache memory port between NUM_REQ requesters (req 0 = IFU fetch, req 1 = LSU).
//   - Requests: round-robin arbitration; a grant is locked until the request handshake completes.
//   - Responses: routed back in issue order, using a FIFO of requester IDs for outstanding reads.
//   - Sits between the requesters' uncache_mem_* interfaces and the uncache memory/bus bridge.

---
 rtl/uncache_mem_arbiter_pkg.sv | 20 ++
 rtl/uncache_mem_arbiter_if.sv | 40 ++++
 rtl/uncache_tag_fifo.sv | 50 +++++
 rtl/uncache_mem_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/uncache_mem_arbiter_pkg.sv
// Shared definitions for the uncache memory arbiter: size codes, requester IDs
// and the tag-width helper used to size requester-ID storage.
package uncache_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    SZ_B = 3'd0,
    SZ_H = 3'd1,
    SZ_W = 3'd2,
    SZ_D = 3'd3
  } uncache_size_e;

  localparam int REQ_IFU = 0;
  localparam int REQ_LSU = 1;

  // A single requester still needs a one-bit tag to keep vectors legal.
  function automatic int tag_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uncache_mem_arbiter_if.sv
// Bundle of requester-side and memory-side handshake signals around the arbiter.
// The arbiter uses the slave view; the environment (requesters + memory) uses master.
interface uncache_mem_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_vld_i;
  logic [NUM_REQ-1:0]        req_rdy_o;
  logic [NUM_REQ-1:0]        req_write_i;
  logic [3*NUM_REQ-1:0]      req_size_i;
  logic [ADDR_W*NUM_REQ-1:0] req_addr_i;
  logic [DATA_W*NUM_REQ-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        resp_vld_o;
  logic [NUM_REQ-1:0]        resp_rdy_i;
  logic [DATA_W-1:0]         resp_data_o;
  logic                      mem_vld_o;
  logic                      mem_ready_i;
  logic                      mem_write_o;
  logic [2:0]                mem_size_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic                      mem_resp_vld_i;
  logic                      mem_resp_rdy_o;
  logic [DATA_W-1:0]         mem_resp_data_i;

  modport slave (
    input  req_vld_i, req_write_i, req_size_i, req_addr_i, req_wdata_i, resp_rdy_i,
    input  mem_ready_i, mem_resp_vld_i, mem_resp_data_i,
    output req_rdy_o, resp_vld_o, resp_data_o,
    output mem_vld_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o, mem_resp_rdy_o
  );

  modport master (
    output req_vld_i, req_write_i, req_size_i, req_addr_i, req_wdata_i, resp_rdy_i,
    output mem_ready_i, mem_resp_vld_i, mem_resp_data_i,
    input  req_rdy_o, resp_vld_o, resp_data_o,
    input  mem_vld_o, mem_write_o, mem_size_o, mem_addr_o, mem_wdata_o, mem_resp_rdy_o
  );
endinterface

// File: rtl/uncache_tag_fifo.sv
// Synchronous FIFO of requester IDs for reads awaiting a response.
// Head entry is read combinationally so responses route with no added latency.
module uncache_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/uncache_mem_arbiter.sv
// Round-robin arbiter sharing one uncache memory port among requesters; read
// responses are routed back in issue order through a tag FIFO of requester IDs.
module uncache_mem_arbiter
  import uncache_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 64,
  localparam int TAG_W = tag_width(NUM_REQ),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  uncache_mem_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  proto_err_o
);
  logic [TAG_W-1:0]  rr_ptr_q, lock_id_q, sel, sel_inc, cand, head;
  logic              lock_q, proto_err_q, found;
  logic              fifo_full, fifo_empty, blocked, hs, push, pop, resp_ok;
  logic [2:0]        size_arr  [NUM_REQ];
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  int                idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign size_arr[gi]         = bus.req_size_i[3*gi +: 3];
    assign addr_arr[gi]         = bus.req_addr_i[ADDR_W*gi +: ADDR_W];
    assign wdata_arr[gi]        = bus.req_wdata_i[DATA_W*gi +: DATA_W];
    assign bus.req_rdy_o[gi]    = hs && (sel == TAG_W'(gi));
    assign bus.resp_vld_o[gi]   = resp_ok && (head == TAG_W'(gi));
  end

  // Rotating priority scan starting at rr_ptr; a held lock overrides it.
  always_comb begin
    sel   = rr_ptr_q;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = TAG_W'(idx);
      if (!found && bus.req_vld_i[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    if (lock_q) sel = lock_id_q;
  end

  assign sel_inc = (int'(sel) == NUM_REQ - 1) ? '0 : sel + TAG_W'(1);

  // Full-FIFO check uses the registered count only: a same-cycle pop does not free a slot.
  assign blocked         = !bus.req_write_i[sel] && fifo_full;
  assign bus.mem_vld_o   = !rst && bus.req_vld_i[sel] && !blocked;
  assign bus.mem_write_o = bus.req_write_i[sel];
  assign bus.mem_size_o  = size_arr[sel];
  assign bus.mem_addr_o  = addr_arr[sel];
  assign bus.mem_wdata_o = wdata_arr[sel];
  assign hs              = bus.mem_vld_o && bus.mem_ready_i;
  assign push            = hs && !bus.req_write_i[sel];

  // With nothing outstanding, responses are swallowed (and flagged) rather than stalled.
  assign resp_ok            = !rst && bus.mem_resp_vld_i && !fifo_empty;
  assign bus.mem_resp_rdy_o = !rst && (fifo_empty ? 1'b1 : bus.resp_rdy_i[head]);
  assign bus.resp_data_o    = bus.mem_resp_data_i;
  assign pop                = bus.mem_resp_vld_i && bus.mem_resp_rdy_o && !fifo_empty;
  assign proto_err_o        = proto_err_q;

  uncache_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (sel),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (outstanding_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_id_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (hs) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= sel_inc;
      end else if (bus.mem_vld_o) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel;
      end
      if (bus.mem_resp_vld_i && fifo_empty) proto_err_q <= 1'b1;
    end
  end
endmodule
